// File: rtl/ram_writeback.sv
// Result-memory to external-RAM writeback engine: unpacks 9-value words (or plain words) into SIZE_1 writes.
// Optional WRITEBACK_RELU_EN clamps negative slices to zero. The packed/plain select port is packed_mode ("packed" is reserved).

module ram_writeback_lane #(
  parameter int W = 11
) (
  input  logic [W-1:0] raw,
  output logic [W-1:0] val
);
`ifdef WRITEBACK_RELU_EN
  assign val = raw[W-1] ? '0 : raw;
`else
  assign val = raw;
`endif
endmodule

module ram_writeback #(
  parameter int SIZE_1           = 11,
  parameter int SIZE_9           = 99,
  parameter int SIZE_address_pix = 13
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        GO,
  input  logic                        packed_mode,
  input  logic [12:0]                 firstaddr,
  input  logic [12:0]                 count,
  output logic                        re_mem,
  output logic [SIZE_address_pix-1:0] addr_mem,
  input  logic [SIZE_9-1:0]           data_mem,
  output logic                        we_RAM,
  output logic [12:0]                 address,
  output logic signed [SIZE_1-1:0]    data_out,
  output logic                        busy,
  output logic                        done
);
  localparam int LANES = SIZE_9 / SIZE_1;
  localparam int KW    = $clog2(LANES);

  typedef enum logic [2:0] {IDLE, READ, LOAD, WRITE, FIN} state_t;

  state_t                        state, state_nxt;
  logic                          pk_q;
  logic [12:0]                   first_q, count_q, n_q;
  logic [KW-1:0]                 k_q;
  logic [SIZE_9-1:0]             buff;
  logic [SIZE_address_pix-1:0]   addr_q;
  logic [12:0]                   addr_hold;
  logic [SIZE_1-1:0]             data_hold;
  logic [LANES-1:0][SIZE_1-1:0]  lane_val;
  logic [SIZE_1-1:0]             slice;
  logic                          last_val, k_wrap;

  // Lane g holds slice g counted from the MSB; plain mode uses the LSB lane.
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    ram_writeback_lane #(.W(SIZE_1)) u_lane (
      .raw (buff[SIZE_9-1-g*SIZE_1 -: SIZE_1]),
      .val (lane_val[g])
    );
  end

  assign slice    = pk_q ? lane_val[k_q] : lane_val[LANES-1];
  assign last_val = (n_q + 13'd1) == count_q;
  assign k_wrap   = k_q == KW'(LANES-1);
  assign addr_mem = addr_q;
  assign busy     = state != IDLE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    re_mem    = 1'b0;
    we_RAM    = 1'b0;
    done      = 1'b0;
    address   = addr_hold;
    data_out  = data_hold;
    case (state)
      IDLE:  if (GO) state_nxt = (count == 13'd0) ? FIN : READ;
      READ:  begin re_mem = 1'b1; state_nxt = LOAD; end
      LOAD:  state_nxt = WRITE;
      WRITE: begin
        we_RAM   = 1'b1;
        address  = first_q + n_q;
        data_out = slice;
        if (last_val)               state_nxt = FIN;
        else if (!pk_q || k_wrap)   state_nxt = READ;
        else                        state_nxt = WRITE;
      end
      FIN:   begin done = 1'b1; state_nxt = IDLE; end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pk_q      <= 1'b0;
      first_q   <= '0;
      count_q   <= '0;
      n_q       <= '0;
      k_q       <= '0;
      buff      <= '0;
      addr_q    <= '0;
      addr_hold <= '0;
      data_hold <= '0;
    end else begin
      case (state)
        IDLE: if (GO) begin
          pk_q    <= packed_mode;
          first_q <= firstaddr;
          count_q <= count;
          n_q     <= '0;
          k_q     <= '0;
          addr_q  <= '0;
        end
        LOAD: buff <= data_mem;
        WRITE: begin
          // Remember the last write so address/data_out hold between strobes.
          addr_hold <= address;
          data_hold <= slice;
          n_q       <= n_q + 13'd1;
          if (pk_q) k_q <= k_wrap ? '0 : k_q + KW'(1);
          if (!last_val && (!pk_q || k_wrap)) addr_q <= addr_q + 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_ram_writeback.sv
// Scoreboard bench for ram_writeback: random result memory, expected writes from a slice-index model.
module tb_ram_writeback;
  localparam int S1 = 11, S9 = 99, AW = 13;

  logic clk = 1'b0, rst_n = 1'b0, GO = 1'b0, packed_mode = 1'b0;
  logic [12:0] firstaddr = '0, count = '0;
  logic re_mem, we_RAM, busy, done;
  logic [AW-1:0] addr_mem;
  logic [S9-1:0] data_mem;
  logic [12:0] address;
  logic signed [S1-1:0] data_out;

  ram_writeback dut (
    .clk(clk), .rst_n(rst_n), .GO(GO), .packed_mode(packed_mode),
    .firstaddr(firstaddr), .count(count), .re_mem(re_mem), .addr_mem(addr_mem),
    .data_mem(data_mem), .we_RAM(we_RAM), .address(address), .data_out(data_out),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [S9-1:0] mem [0:255];
  always @(posedge clk) if (re_mem) data_mem <= mem[addr_mem[7:0]];

  int checks = 0, fails = 0;
  typedef struct packed { logic [12:0] a; logic [10:0] d; } wr_t;
  wr_t exp_q[$];
  int re_cnt = 0, wr_seen = 0;
  logic [12:0] last_a = '0;
  logic [10:0] last_d = '0;
  wr_t mon_e;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [10:0] exp_val(int i, bit pk);
    logic [98:0] w;
    logic [10:0] v;
    if (pk) begin w = mem[i/9]; v = w[98 - 11*(i%9) -: 11]; end
    else    begin w = mem[i];   v = w[10:0]; end
`ifdef WRITEBACK_RELU_EN
    if (v[10]) v = '0;
`endif
    return v;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("reset_we", we_RAM, 0);   chk("reset_re", re_mem, 0);
      chk("reset_busy", busy, 0);   chk("reset_done", done, 0);
      chk("reset_addr", address, 0); chk("reset_data", {53'd0, data_out}, 0);
      chk("reset_addr_mem", addr_mem, 0);
      last_a = '0; last_d = '0;
    end else begin
      chk("strobe_excl", re_mem & we_RAM, 0);
      if (re_mem) re_cnt++;
      if (we_RAM) begin
        wr_seen++;
        if (exp_q.size() == 0) chk("unexpected_write", 1, 0);
        else begin
          mon_e = exp_q.pop_front();
          chk("wr_addr", address, mon_e.a);
          chk("wr_data", {53'd0, data_out}, mon_e.d);
        end
        last_a = address; last_d = data_out;
      end else begin
        chk("hold_addr", address, last_a);
        chk("hold_data", {53'd0, data_out}, last_d);
      end
    end
  end

  task automatic push_exp(input bit pk, input logic [12:0] fa, input logic [12:0] cnt);
    wr_t e;
    for (int i = 0; i < int'(cnt); i++) begin
      e.a = fa + i[12:0];
      e.d = exp_val(i, pk);
      exp_q.push_back(e);
    end
  endtask

  task automatic issue_go(input bit pk, input logic [12:0] fa, input logic [12:0] cnt);
    @(negedge clk);
    re_cnt = 0; GO = 1'b1; packed_mode = pk; firstaddr = fa; count = cnt;
    @(negedge clk);
    GO = 1'b0; packed_mode = 1'($urandom); firstaddr = 13'($urandom); count = 13'($urandom);
  endtask

  task automatic run_op(input bit pk, input logic [12:0] fa, input logic [12:0] cnt, input bit go_mid);
    int cyc, words, total;
    push_exp(pk, fa, cnt);
    words = pk ? (int'(cnt) + 8) / 9 : int'(cnt);
    total = pk ? 11*words - (9*words - int'(cnt)) + 1 : 3*int'(cnt) + 1;
    issue_go(pk, fa, cnt);
    chk("busy_after_go", busy, 1);
    cyc = 1;
    while (!done && cyc < 2000) begin
      GO = go_mid && cyc == 3;
      @(negedge clk);
      cyc++;
    end
    GO = 1'b0;
    chk("done_seen", done, 1);
    chk("cycles", cyc, total);
    chk("re_count", re_cnt, words);
    chk("exp_drained", exp_q.size(), 0);
    chk("busy_in_fin", busy, 1);
    @(negedge clk);
    chk("done_pulse", done, 0);
    chk("busy_idle", busy, 0);
    exp_q.delete();
  endtask

  task automatic reset_mid();
    int cyc, base;
    push_exp(1'b1, 13'd50, 13'd20);
    base = wr_seen;
    issue_go(1'b1, 13'd50, 13'd20);
    cyc = 0;
    while (wr_seen < base + 4 && cyc < 200) begin
      @(negedge clk); #2; cyc++;
    end
    chk("reached_4th_write", we_RAM, 1);
    rst_n = 1'b0;
    #1;
    chk("async_we", we_RAM, 0);     chk("async_re", re_mem, 0);
    chk("async_addr", address, 0);  chk("async_data", {53'd0, data_out}, 0);
    chk("async_busy", busy, 0);     chk("async_addr_mem", addr_mem, 0);
    exp_q.delete();
    repeat (3) begin @(negedge clk); chk("no_done_in_reset", done, 0); end
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("no_done_after_reset", done, 0);
  endtask

  initial begin
    logic [127:0] t;
    for (int i = 0; i < 256; i++) begin
      t = {$urandom, $urandom, $urandom, $urandom};
      mem[i] = t[98:0];
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    mem[0][10:0] = 11'd5; mem[1][10:0] = 11'h7FD; mem[2][10:0] = 11'd7;
    run_op(1'b0, 13'd100, 13'd3, 1'b0);

    mem[0] = {11'd1, 11'd2, 11'd3, 11'd4, 11'd5, 11'd6, 11'd7, 11'd8, 11'd9};
    run_op(1'b1, 13'd0, 13'd9, 1'b0);

    for (int i = 0; i < 2; i++) begin t = {$urandom, $urandom, $urandom, $urandom}; mem[i] = t[98:0]; end
    run_op(1'b1, 13'd0, 13'd11, 1'b0);

    run_op(1'b1, 13'd5, 13'd0, 1'b0);
    run_op(1'b0, 13'd5, 13'd0, 1'b0);
    run_op(1'b1, 13'd20, 13'd15, 1'b1);
    run_op(1'b0, 13'd8190, 13'd5, 1'b1);

    reset_mid();
    run_op(1'b1, 13'd50, 13'd20, 1'b0);

    repeat (12) run_op(1'($urandom_range(0, 1)), 13'($urandom), 13'($urandom_range(1, 40)),
                       1'($urandom_range(0, 1)));

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
